// File: rtl/dct_block_sequencer.sv
// Sequencer for the 8x8 2D-DCT: for each output coefficient (u,v) it streams all 64
// pixel/cosine reads into the MAC, waits out read+MAC latency, then writes the result.
module dct_block_sequencer #(
  parameter int RD_LAT  = 1,
  parameter int MAC_LAT = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Abort,
  output logic       Busy,
  output logic       Done,
  output logic       Pix_Rd_En,
  output logic [5:0] Pix_Addr,
  output logic [5:0] Coef_Row_Addr,
  output logic [5:0] Coef_Col_Addr,
  output logic       MAC_En,
  output logic       MAC_Clear,
  output logic       Res_Wr_En,
  output logic [5:0] Res_Addr
);
  localparam int DRAIN_LEN = RD_LAT + MAC_LAT - 1;
  localparam int DW        = $clog2(DRAIN_LEN + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_WRITE, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [5:0]        xy_q, xy_d;   // {x,y}: y is the inner loop
  logic [5:0]        uv_q, uv_d;   // {u,v}: v is the inner loop
  logic [DW-1:0]     drain_q, drain_d;
  logic [RD_LAT-1:0] vld_pipe_q, vld_pipe_d;
  logic [RD_LAT-1:0] clr_pipe_q, clr_pipe_d;
  logic              rd_en, wr_en, flush;

  assign rd_en = (state_q == S_ISSUE);
  assign wr_en = (state_q == S_WRITE);

  always_comb begin
    state_d = state_q;
    xy_d    = xy_q;
    uv_d    = uv_q;
    drain_d = drain_q;
    flush   = 1'b0;
    case (state_q)
      S_IDLE:  if (Start && !Abort) state_d = S_ISSUE;
      S_ISSUE: begin
        xy_d = xy_q + 6'd1;
        if (xy_q == 6'd63) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end
      end
      S_DRAIN: begin
        if (drain_q == DW'(DRAIN_LEN - 1)) state_d = S_WRITE;
        else drain_d = drain_q + DW'(1);
      end
      S_WRITE: begin
        uv_d    = uv_q + 6'd1;
        state_d = (uv_q == 6'd63) ? S_DONE : S_ISSUE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort cancels everything in flight; a write already on the bus this cycle still lands.
    if (Abort && (rd_en || wr_en || state_q == S_DRAIN)) begin
      state_d = S_IDLE;
      xy_d    = '0;
      uv_d    = '0;
      drain_d = '0;
      flush   = 1'b1;
    end
  end

  // Read strobe and first-read marker travel together so MAC_Clear aligns with its MAC_En.
  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    clr_pipe_d    = clr_pipe_q;
    vld_pipe_d[0] = rd_en;
    clr_pipe_d[0] = rd_en && (xy_q == 6'd0);
    for (int i = 1; i < RD_LAT; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      clr_pipe_d[i] = clr_pipe_q[i-1];
    end
    if (flush) begin
      vld_pipe_d = '0;
      clr_pipe_d = '0;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      xy_q       <= '0;
      uv_q       <= '0;
      drain_q    <= '0;
      vld_pipe_q <= '0;
      clr_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      xy_q       <= xy_d;
      uv_q       <= uv_d;
      drain_q    <= drain_d;
      vld_pipe_q <= vld_pipe_d;
      clr_pipe_q <= clr_pipe_d;
    end
  end

  assign Busy          = rd_en || wr_en || (state_q == S_DRAIN);
  assign Done          = (state_q == S_DONE);
  assign Pix_Rd_En     = rd_en;
  assign Pix_Addr      = rd_en ? xy_q : 6'd0;
  assign Coef_Row_Addr = rd_en ? {uv_q[5:3], xy_q[5:3]} : 6'd0;
  assign Coef_Col_Addr = rd_en ? {uv_q[2:0], xy_q[2:0]} : 6'd0;
  assign MAC_En        = vld_pipe_q[RD_LAT-1];
  assign MAC_Clear     = clr_pipe_q[RD_LAT-1];
  assign Res_Wr_En     = wr_en;
  assign Res_Addr      = wr_en ? uv_q : 6'd0;

endmodule

// File: tb/tb_dct_block_sequencer.sv
// Bench for dct_block_sequencer: expected reads/MACs/writes are queued from the
// loop formulas when a run starts and popped as the DUT strobes them.
module tb_dct_block_sequencer;
  localparam int RD  = 1;
  localparam int ML  = 1;
  localparam int PER = 64 + RD + ML;

  logic Clock = 1'b0, Reset = 1'b1;
  logic Start = 1'b0, Abort = 1'b0;
  logic Busy, Done, Pix_Rd_En, MAC_En, MAC_Clear, Res_Wr_En;
  logic [5:0] Pix_Addr, Coef_Row_Addr, Coef_Col_Addr, Res_Addr;

  logic Start2 = 1'b0, Abort2 = 1'b0;
  logic Busy2, Done2, Pix_Rd_En2, MAC_En2, MAC_Clear2, Res_Wr_En2;
  logic [5:0] Pix_Addr2, Coef_Row_Addr2, Coef_Col_Addr2, Res_Addr2;

  dct_block_sequencer #(.RD_LAT(RD), .MAC_LAT(ML)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Abort(Abort), .Busy(Busy), .Done(Done),
    .Pix_Rd_En(Pix_Rd_En), .Pix_Addr(Pix_Addr), .Coef_Row_Addr(Coef_Row_Addr),
    .Coef_Col_Addr(Coef_Col_Addr), .MAC_En(MAC_En), .MAC_Clear(MAC_Clear),
    .Res_Wr_En(Res_Wr_En), .Res_Addr(Res_Addr));

  dct_block_sequencer #(.RD_LAT(3), .MAC_LAT(2)) dut2 (
    .Clock(Clock), .Reset(Reset), .Start(Start2), .Abort(Abort2), .Busy(Busy2), .Done(Done2),
    .Pix_Rd_En(Pix_Rd_En2), .Pix_Addr(Pix_Addr2), .Coef_Row_Addr(Coef_Row_Addr2),
    .Coef_Col_Addr(Coef_Col_Addr2), .MAC_En(MAC_En2), .MAC_Clear(MAC_Clear2),
    .Res_Wr_En(Res_Wr_En2), .Res_Addr(Res_Addr2));

  always #5 Clock = ~Clock;

  typedef struct { int cyc; logic [5:0] pix; logic [5:0] row; logic [5:0] col; } rd_t;
  typedef struct { int cyc; logic clr; } mac_t;
  typedef struct { int cyc; logic [5:0] addr; } wr_t;

  rd_t  rd_q[$];
  mac_t mac_q[$];
  wr_t  wr_q[$];

  int n_cmp = 0, n_bad = 0;
  int cnt = 0, t0 = 0, exp_done = -1;
  int mac_cnt = 0, clr_cnt = 0, wr_cnt = 0, done_cnt = 0;
  bit sb_on = 1'b0;
  logic prev_busy = 1'b0;

  always @(posedge Clock) cnt <= cnt + 1;

  function automatic logic [29:0] all_out();
    return {Busy, Done, Pix_Rd_En, MAC_En, MAC_Clear, Res_Wr_En,
            Pix_Addr, Coef_Row_Addr, Coef_Col_Addr, Res_Addr};
  endfunction

  function automatic logic [29:0] all_out2();
    return {Busy2, Done2, Pix_Rd_En2, MAC_En2, MAC_Clear2, Res_Wr_En2,
            Pix_Addr2, Coef_Row_Addr2, Coef_Col_Addr2, Res_Addr2};
  endfunction

  // Scoreboard monitor for the default-latency instance.
  always @(negedge Clock) begin : mon
    int c;
    rd_t er;
    mac_t em;
    wr_t ew;
    c = cnt - t0 + 1;
    if (sb_on) begin
      n_cmp++;
      if ((!Pix_Rd_En && (Pix_Addr | Coef_Row_Addr | Coef_Col_Addr) !== 6'd0) ||
          (!Res_Wr_En && Res_Addr !== 6'd0) || (MAC_Clear && !MAC_En)) begin
        n_bad++;
        $display("FAIL quiet_outputs cyc=%0d got rd=%b pix=%0d row=%0d col=%0d wr=%b res=%0d en=%b clr=%b required addresses 0 with strobe low",
                 c, Pix_Rd_En, Pix_Addr, Coef_Row_Addr, Coef_Col_Addr, Res_Wr_En, Res_Addr, MAC_En, MAC_Clear);
      end
      if (Pix_Rd_En) begin
        n_cmp++;
        if (rd_q.size() == 0) begin
          n_bad++;
          $display("FAIL read_unexpected cyc=%0d got pix=%0d required no read", c, Pix_Addr);
        end else begin
          er = rd_q.pop_front();
          if (er.cyc != c || er.pix !== Pix_Addr || er.row !== Coef_Row_Addr || er.col !== Coef_Col_Addr) begin
            n_bad++;
            $display("FAIL read cyc=%0d pix=%0d row=%0d col=%0d required cyc=%0d pix=%0d row=%0d col=%0d",
                     c, Pix_Addr, Coef_Row_Addr, Coef_Col_Addr, er.cyc, er.pix, er.row, er.col);
          end
        end
      end
      if (MAC_En) begin
        mac_cnt++;
        if (MAC_Clear) clr_cnt++;
        n_cmp++;
        if (mac_q.size() == 0) begin
          n_bad++;
          $display("FAIL mac_unexpected cyc=%0d required no MAC_En", c);
        end else begin
          em = mac_q.pop_front();
          if (em.cyc != c || em.clr !== MAC_Clear) begin
            n_bad++;
            $display("FAIL mac cyc=%0d clr=%b required cyc=%0d clr=%b", c, MAC_Clear, em.cyc, em.clr);
          end
        end
      end
      if (Res_Wr_En) begin
        wr_cnt++;
        n_cmp++;
        if (wr_q.size() == 0) begin
          n_bad++;
          $display("FAIL write_unexpected cyc=%0d addr=%0d required no write", c, Res_Addr);
        end else begin
          ew = wr_q.pop_front();
          if (ew.cyc != c || ew.addr !== Res_Addr) begin
            n_bad++;
            $display("FAIL write cyc=%0d addr=%0d required cyc=%0d addr=%0d", c, Res_Addr, ew.cyc, ew.addr);
          end
        end
      end
      if (Done) begin
        done_cnt++;
        n_cmp++;
        if (c != exp_done || Busy !== 1'b0 || prev_busy !== 1'b1) begin
          n_bad++;
          $display("FAIL done cyc=%0d busy=%b prev_busy=%b required cyc=%0d busy=0 prev_busy=1",
                   c, Busy, prev_busy, exp_done);
        end
      end
    end
    prev_busy = Busy;
  end

  task automatic push_coef(input int c, input int nrd, input int nmac, input bit wr);
    int base;
    base = 1 + c * PER;
    for (int i = 0; i < nrd; i++)
      rd_q.push_back('{base + i, 6'(i), {3'(c >> 3), 3'(i >> 3)}, {3'(c & 7), 3'(i & 7)}});
    for (int i = 0; i < nmac; i++)
      mac_q.push_back('{base + i + RD, (i == 0)});
    if (wr) wr_q.push_back('{base + 63 + RD + ML, 6'(c)});
  endtask

  task automatic clr_stats();
    mac_cnt = 0; clr_cnt = 0; wr_cnt = 0; done_cnt = 0;
  endtask

  // Start is sampled at the next rising edge ("edge 0"); cycle 1 follows it.
  task automatic start_run();
    @(negedge Clock);
    Start = 1'b1;
    t0 = cnt + 1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic wait_cycle(input int target);
    for (int k = 0; k < 5000; k++) begin
      if (cnt - t0 + 1 == target) break;
      @(negedge Clock);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge Clock);
      Start = 1'($urandom_range(0, 1));
      Start2 = 1'($urandom_range(0, 1));
      n_cmp++;
      if (all_out() !== 30'd0 || all_out2() !== 30'd0) begin
        n_bad++;
        $display("FAIL reset_hold got %h / %h required 0", all_out(), all_out2());
      end
    end
    Start = 1'b0; Start2 = 1'b0;
    Reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clock);
      n_cmp++;
      if (all_out() !== 30'd0 || all_out2() !== 30'd0) begin
        n_bad++;
        $display("FAIL reset_idle got %h / %h required 0", all_out(), all_out2());
      end
    end
  endtask

  task automatic test_latency();
    int tl, c, first_clr, wr1, wr2, last_rd, drain, nclr;
    first_clr = -1; wr1 = -1; wr2 = -1; last_rd = -1; drain = 0; nclr = 0;
    @(negedge Clock);
    Start2 = 1'b1;
    tl = cnt + 1;
    for (int k = 0; k < 140; k++) begin
      @(negedge Clock);
      Start2 = 1'b0;
      c = cnt - tl + 1;
      if (MAC_Clear2) begin
        nclr++;
        if (first_clr < 0) first_clr = c;
      end
      if (Res_Wr_En2) begin
        if (wr1 < 0) wr1 = c;
        else if (wr2 < 0) wr2 = c;
      end
      if (Pix_Rd_En2 && wr1 < 0) last_rd = c;
      if (Busy2 && !Pix_Rd_En2 && !Res_Wr_En2 && wr1 < 0) drain++;
    end
    Abort2 = 1'b1;
    @(negedge Clock);
    Abort2 = 1'b0;
    n_cmp++;
    if (first_clr != 4) begin n_bad++; $display("FAIL lat_first_clear got %0d required 4", first_clr); end
    n_cmp++;
    if (wr1 != 69) begin n_bad++; $display("FAIL lat_first_write got %0d required 69", wr1); end
    n_cmp++;
    if (wr2 != 138) begin n_bad++; $display("FAIL lat_period got %0d required 138", wr2); end
    n_cmp++;
    if (drain != 4 || last_rd != 64) begin
      n_bad++; $display("FAIL lat_drain got len=%0d last_rd=%0d required len=4 last_rd=64", drain, last_rd);
    end
    n_cmp++;
    if (nclr != 2) begin n_bad++; $display("FAIL lat_clear_count got %0d required 2", nclr); end
    n_cmp++;
    if (Busy2 !== 1'b0) begin n_bad++; $display("FAIL lat_abort_busy got %b required 0", Busy2); end
  endtask

  task automatic test_full_run();
    bit got;
    clr_stats();
    for (int c = 0; c < 64; c++) push_coef(c, 64, 64, 1'b1);
    exp_done = 64 * PER + 1;
    sb_on = 1'b1;
    start_run();
    got = 1'b0;
    for (int k = 0; k < 4400 && !got; k++) begin
      @(negedge Clock);
      Start = (cnt - t0 + 1 == 1000);
      if (Done) begin
        got = 1'b1;
        Start = 1'b1;
      end
    end
    @(negedge Clock);
    Start = 1'b0;
    n_cmp++;
    if (!got) begin n_bad++; $display("FAIL full_done_timeout got no Done required Done at %0d", exp_done); end
    repeat (80) @(negedge Clock);
    n_cmp++;
    if (Busy !== 1'b0) begin n_bad++; $display("FAIL done_start_ignored got busy=%b required 0", Busy); end
    n_cmp++;
    if (mac_cnt != 4096) begin n_bad++; $display("FAIL full_mac_count got %0d required 4096", mac_cnt); end
    n_cmp++;
    if (clr_cnt != 64) begin n_bad++; $display("FAIL full_clear_count got %0d required 64", clr_cnt); end
    n_cmp++;
    if (wr_cnt != 64 || done_cnt != 1) begin
      n_bad++; $display("FAIL full_write_done got wr=%0d done=%0d required 64/1", wr_cnt, done_cnt);
    end
    n_cmp++;
    if (rd_q.size() + mac_q.size() + wr_q.size() != 0) begin
      n_bad++; $display("FAIL full_leftover got %0d/%0d/%0d required 0", rd_q.size(), mac_q.size(), wr_q.size());
      rd_q.delete(); mac_q.delete(); wr_q.delete();
    end
  endtask

  task automatic test_abort();
    clr_stats();
    exp_done = -1;
    for (int c = 0; c < 5; c++) push_coef(c, 64, 64, 1'b1);
    push_coef(5, 21, 20, 1'b0);
    start_run();
    wait_cycle(1 + 5 * PER + 20);
    n_cmp++;
    if (Pix_Addr !== 6'd20 || Busy !== 1'b1) begin
      n_bad++; $display("FAIL abort_setup got pix=%0d busy=%b required 20/1", Pix_Addr, Busy);
    end
    Abort = 1'b1;
    @(negedge Clock);
    Abort = 1'b0;
    n_cmp++;
    if (Busy !== 1'b0 || Pix_Rd_En !== 1'b0) begin
      n_bad++; $display("FAIL abort_idle got busy=%b rd=%b required 0/0", Busy, Pix_Rd_En);
    end
    repeat (80) @(negedge Clock);
    n_cmp++;
    if (wr_cnt != 5 || done_cnt != 0 || rd_q.size() + mac_q.size() + wr_q.size() != 0) begin
      n_bad++; $display("FAIL abort_after got wr=%0d done=%0d left=%0d required 5/0/0",
                        wr_cnt, done_cnt, rd_q.size() + mac_q.size() + wr_q.size());
      rd_q.delete(); mac_q.delete(); wr_q.delete();
    end
    // Abort and Start together in IDLE: nothing starts.
    @(negedge Clock);
    Start = 1'b1; Abort = 1'b1;
    @(negedge Clock);
    Start = 1'b0; Abort = 1'b0;
    n_cmp++;
    if (Busy !== 1'b0) begin n_bad++; $display("FAIL abort_beats_start got busy=%b required 0", Busy); end
    repeat (3) @(negedge Clock);
  endtask

  task automatic test_restart_reset_drain();
    clr_stats();
    push_coef(0, 64, 64, 1'b1);
    push_coef(1, 64, 64, 1'b0);
    start_run();
    wait_cycle(2 * PER - 1);
    n_cmp++;
    if (Busy !== 1'b1 || Pix_Rd_En !== 1'b0 || Res_Wr_En !== 1'b0) begin
      n_bad++; $display("FAIL drain_setup got busy=%b rd=%b wr=%b required 1/0/0", Busy, Pix_Rd_En, Res_Wr_En);
    end
    #2 Reset = 1'b0;
    #1;
    n_cmp++;
    if (all_out() !== 30'd0) begin n_bad++; $display("FAIL reset_mid_drain got %h required 0", all_out()); end
    @(negedge Clock);
    Reset = 1'b1;
    repeat (10) @(negedge Clock);
    n_cmp++;
    if (wr_cnt != 1 || done_cnt != 0 || rd_q.size() + mac_q.size() + wr_q.size() != 0) begin
      n_bad++; $display("FAIL reset_after got wr=%0d done=%0d left=%0d required 1/0/0",
                        wr_cnt, done_cnt, rd_q.size() + mac_q.size() + wr_q.size());
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_latency();
    test_full_run();
    test_abort();
    test_restart_reset_drain();
    sb_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
